bk_sector_ctrl: RTL and testbench
=================================

BK_SECTOR_CTRL -- requirements
Module: bk_sector_ctrl

Interface
REQ-001 SHALL have parameter SECTORS, default 64, meaning sectors per save slot (power of two, 2..256).
REQ-002 SHALL have parameter SLOT_W, default 2, meaning slot-select width.
REQ-003 SHALL have parameter AUTOSAVE_TICKS, default 300, meaning idle ticks before autosave (used only under BK_AUTOSAVE_EN).
REQ-004 SHALL have port clk_sys  in  1  system clock; all logic on rising edge.
REQ-005 SHALL have port RESET_n  in  1  reset, asynchronous and active-low.
REQ-006 SHALL have port downloading  in  1  ROM download in progress.
REQ-007 SHALL have ports img_mounted  in  1, img_readonly  in  1 and img_size  in  64, meaning save-image mount strobe, read-only flag and image size.
REQ-008 SHALL have ports slot  in  SLOT_W, load_req  in  1 and save_req  in  1, meaning OSD slot select, load level and save level.
REQ-009 SHALL have port sd_ack  in  1  HPS sector-transfer acknowledge.
REQ-010 SHALL have ports sd_lba  out  32, sd_rd  out  1 and sd_wr  out  1, meaning sector address, read request and write request.
REQ-011 SHALL have ports bk_ena  out  1, bk_loading  out  1 and bk_busy  out  1, meaning save enabled, load in progress (holds system reset) and transfer active (LED).
REQ-012 SHALL have ports dirty_set  in  1 and autosave_tick  in  1, meaning backup RAM write strobe and per-frame pulse; these are present only under BK_AUTOSAVE_EN.

Function
REQ-013 SHALL clear bk_ena on the rising edge of downloading.
REQ-014 SHALL set bk_ena in any cycle where downloading, img_mounted, img_size!=0 and !img_readonly all hold.
REQ-015 SHALL detect load and save requests only on a 0->1 edge of (req & bk_ena); level-high requests never retrigger.
REQ-016 SHALL use states IDLE, ISSUE, WAIT_ACK_HI and WAIT_ACK_LO.
REQ-017 SHALL, in IDLE on a request edge, go to ISSUE and latch direction, with load winning if both edges occur in the same cycle.
REQ-018 SHALL, on the IDLE-to-ISSUE transition, latch slot, set sd_lba = slot*SECTORS and set bk_loading = direction==load.
REQ-019 SHALL, in ISSUE, assert sd_rd for a load or sd_wr for a save, then go to WAIT_ACK_HI.
REQ-020 SHALL, in WAIT_ACK_HI on the sd_ack rising edge, deassert sd_rd/sd_wr the same cycle and go to WAIT_ACK_LO.
REQ-021 SHALL, in WAIT_ACK_LO on the sd_ack falling edge, return to IDLE and clear bk_loading if the low log2(SECTORS) bits of sd_lba are all 1, otherwise increment sd_lba and return to ISSUE.
REQ-022 SHALL keep the sector index wrap inside the slot, so the low bits never carry into the slot field.
REQ-023 SHALL ignore request edges and slot changes while not in IDLE.
REQ-024 SHALL drive bk_busy = (state != IDLE).
REQ-025 SHALL keep sd_rd and sd_wr mutually exclusive, each asserted for at most one ack handshake at a time.
REQ-026 SHALL let a falling edge of downloading while busy leave the transfer to complete; it does not abort.

Reset
REQ-027 SHALL, when RESET_n is low, force state IDLE and all outputs 0 (sd_lba=0, sd_rd=0, sd_wr=0, bk_ena=0, bk_loading=0, bk_busy=0).
REQ-028 SHALL reset all edge-detect registers to 0, so a request held high across reset is not seen as an edge.
REQ-029 SHALL abandon a transfer interrupted by reset; no resume.

Configuration
REQ-030 SHALL, with BK_AUTOSAVE_EN defined, set a dirty flag on dirty_set and run an idle counter that counts autosave_tick and clears on dirty_set.
REQ-031 SHALL, with BK_AUTOSAVE_EN defined, start a save in IDLE when dirty, bk_ena is set and the counter reaches AUTOSAVE_TICKS; this uses the current slot, clears dirty at start, and a manual request edge in the same cycle wins.
REQ-032 SHALL, without BK_AUTOSAVE_EN, omit the ports of REQ-012 and the counter logic; behaviour is as in REQ-013 to REQ-026 only.

Structure
REQ-033 SHALL place the state enum and the LBA width constant (32) in shared package bk_pkg.
REQ-034 SHALL place ack and request edge detection in one sub-module, bk_edge_det (rise/fall pulse generator), instantiated per signal.

Verification
REQ-035 SHALL cover: downloading 0->1, then img_mounted with img_size=8192 and img_readonly=0 -> bk_ena=1; a second download rise -> bk_ena=0.
REQ-036 SHALL cover: slot=2, save_req edge, model ack each sector -> 64 sd_wr pulses, sd_lba 128..191, then IDLE with bk_busy=0.
REQ-037 SHALL cover: load_req and save_req rising in the same cycle -> sd_rd=1, sd_wr=0, bk_loading=1 until sector 63 ack falls.
REQ-038 SHALL cover: RESET_n low during sector 10 of a load -> all outputs 0 immediately; after release with load_req held high, no transfer starts.
REQ-039 SHALL cover: with BK_AUTOSAVE_EN and AUTOSAVE_TICKS=3, one dirty_set then 3 ticks -> save of current slot starts; a dirty_set after tick 2 delays the save by 3 further ticks.

Source files
------------

// File: rtl/bk_pkg.sv
// Shared types and constants for the backup-RAM sector controller.
package bk_pkg;

    localparam int unsigned LBA_W = 32;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWaitAckHi,
        StWaitAckLo
    } bk_state_e;

endpackage

// File: rtl/bk_sector_ctrl_if.sv
// Sector-transfer handshake between the backup controller and the HPS side.
interface bk_sector_ctrl_if;
    import bk_pkg::*;

    logic [LBA_W-1:0] sd_lba;
    logic             sd_rd;
    logic             sd_wr;
    logic             sd_ack;

    modport master (
        output sd_lba,
        output sd_rd,
        output sd_wr,
        input  sd_ack
    );

    modport slave (
        input  sd_lba,
        input  sd_rd,
        input  sd_wr,
        output sd_ack
    );

endinterface

// File: rtl/bk_edge_det.sv
// Single-signal rise/fall pulse generator; history register resets low.
module bk_edge_det (
    input  logic clk_sys,
    input  logic RESET_n,
    input  logic sig,
    output logic rise,
    output logic fall
);

    logic sig_q;

    always_ff @(posedge clk_sys or negedge RESET_n) begin
        if (!RESET_n) begin
            sig_q <= 1'b0;
        end else begin
            sig_q <= sig;
        end
    end

    assign rise = sig & ~sig_q;
    assign fall = ~sig & sig_q;

endmodule

// File: rtl/bk_sector_ctrl.sv
// Save-slot load/save sequencer: walks one slot sector by sector over the HPS handshake.
// Define BK_AUTOSAVE_EN to add the dirty-flag/idle-tick autosave and its two ports.
module bk_sector_ctrl
    import bk_pkg::*;
#(
    parameter int unsigned SECTORS        = 64,
    parameter int unsigned SLOT_W         = 2,
    parameter int unsigned AUTOSAVE_TICKS = 300
) (
    input  logic              clk_sys,
    input  logic              RESET_n,
    input  logic              downloading,
    input  logic              img_mounted,
    input  logic              img_readonly,
    input  logic [63:0]       img_size,
    input  logic [SLOT_W-1:0] slot,
    input  logic              load_req,
    input  logic              save_req,
`ifdef BK_AUTOSAVE_EN
    input  logic              dirty_set,
    input  logic              autosave_tick,
`endif
    bk_sector_ctrl_if.master  sd,
    output logic              bk_ena,
    output logic              bk_loading,
    output logic              bk_busy
);

    localparam int unsigned SEC_W = $clog2(SECTORS);

    bk_state_e        state_q;
    logic [LBA_W-1:0] lba_q;
    logic             rd_q;
    logic             wr_q;
    logic             dir_load_q;
    logic             ena_q;
    logic             loading_q;

    logic dl_rise, load_edge, save_edge, ack_rise, ack_fall;
    logic dl_unused_fall, load_unused_fall, save_unused_fall;
    logic auto_start, start, last_sector;

    bk_edge_det u_dl_edge (
        .clk_sys (clk_sys),
        .RESET_n (RESET_n),
        .sig     (downloading),
        .rise    (dl_rise),
        .fall    (dl_unused_fall)
    );

    // Requests are gated by bk_ena before edge detection so enabling with a held request counts.
    bk_edge_det u_load_edge (
        .clk_sys (clk_sys),
        .RESET_n (RESET_n),
        .sig     (load_req & ena_q),
        .rise    (load_edge),
        .fall    (load_unused_fall)
    );

    bk_edge_det u_save_edge (
        .clk_sys (clk_sys),
        .RESET_n (RESET_n),
        .sig     (save_req & ena_q),
        .rise    (save_edge),
        .fall    (save_unused_fall)
    );

    bk_edge_det u_ack_edge (
        .clk_sys (clk_sys),
        .RESET_n (RESET_n),
        .sig     (sd.sd_ack),
        .rise    (ack_rise),
        .fall    (ack_fall)
    );

`ifdef BK_AUTOSAVE_EN
    localparam int unsigned CNT_W = $clog2(AUTOSAVE_TICKS + 1);

    logic [CNT_W-1:0] idle_cnt_q;
    logic             dirty_q;

    // Manual request edges take priority over autosave in the same cycle.
    assign auto_start = (state_q == StIdle) && dirty_q && ena_q && !load_edge && !save_edge &&
                        (idle_cnt_q == CNT_W'(AUTOSAVE_TICKS));

    always_ff @(posedge clk_sys or negedge RESET_n) begin
        if (!RESET_n) begin
            dirty_q    <= 1'b0;
            idle_cnt_q <= '0;
        end else begin
            if (dirty_set) begin
                dirty_q <= 1'b1;
            end else if (auto_start) begin
                dirty_q <= 1'b0;
            end
            if (dirty_set) begin
                idle_cnt_q <= '0;
            end else if (autosave_tick && idle_cnt_q != CNT_W'(AUTOSAVE_TICKS)) begin
                idle_cnt_q <= idle_cnt_q + CNT_W'(1);
            end
        end
    end
`else
    assign auto_start = 1'b0;
`endif

    assign start       = load_edge | save_edge | auto_start;
    assign last_sector = &lba_q[SEC_W-1:0];

    always_ff @(posedge clk_sys or negedge RESET_n) begin
        if (!RESET_n) begin
            ena_q <= 1'b0;
        end else if (downloading && img_mounted && (img_size != 64'd0) && !img_readonly) begin
            ena_q <= 1'b1;
        end else if (dl_rise) begin
            ena_q <= 1'b0;
        end
    end

    always_ff @(posedge clk_sys or negedge RESET_n) begin
        if (!RESET_n) begin
            state_q    <= StIdle;
            lba_q      <= '0;
            rd_q       <= 1'b0;
            wr_q       <= 1'b0;
            dir_load_q <= 1'b0;
            loading_q  <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        state_q    <= StIssue;
                        dir_load_q <= load_edge;
                        loading_q  <= load_edge;
                        lba_q      <= LBA_W'(slot) << SEC_W;
                    end
                end
                StIssue: begin
                    rd_q    <= dir_load_q;
                    wr_q    <= ~dir_load_q;
                    state_q <= StWaitAckHi;
                end
                StWaitAckHi: begin
                    if (ack_rise) begin
                        rd_q    <= 1'b0;
                        wr_q    <= 1'b0;
                        state_q <= StWaitAckLo;
                    end
                end
                StWaitAckLo: begin
                    if (ack_fall) begin
                        if (last_sector) begin
                            state_q   <= StIdle;
                            loading_q <= 1'b0;
                        end else begin
                            // Only the sector field counts; the slot field stays fixed.
                            lba_q   <= {lba_q[LBA_W-1:SEC_W], lba_q[SEC_W-1:0] + SEC_W'(1)};
                            state_q <= StIssue;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign sd.sd_lba  = lba_q;
    assign sd.sd_rd   = rd_q;
    assign sd.sd_wr   = wr_q;
    assign bk_ena     = ena_q;
    assign bk_loading = loading_q;
    assign bk_busy    = (state_q != StIdle);

endmodule

// File: tb/tb_bk_sector_ctrl.sv
// Scoreboard bench for bk_sector_ctrl: an HPS ack model answers every request, a monitor
// checks each sd_rd/sd_wr pulse against queued expectations.
module tb_bk_sector_ctrl;

    typedef struct packed {
        logic [31:0] lba;
        logic        rd;
        logic        wr;
        logic        loading;
    } exp_t;

    logic        clk_sys = 1'b0;
    logic        RESET_n;
    logic        downloading, img_mounted, img_readonly;
    logic [63:0] img_size;
    logic [1:0]  slot;
    logic        load_req, save_req;
    logic        dirty_set, autosave_tick;
    logic        bk_ena, bk_loading, bk_busy;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk_sys = ~clk_sys;

    bk_sector_ctrl_if sd_bus ();

    bk_sector_ctrl #(
        .SECTORS        (64),
        .SLOT_W         (2),
        .AUTOSAVE_TICKS (3)
    ) dut (
        .clk_sys       (clk_sys),
        .RESET_n       (RESET_n),
        .downloading   (downloading),
        .img_mounted   (img_mounted),
        .img_readonly  (img_readonly),
        .img_size      (img_size),
        .slot          (slot),
        .load_req      (load_req),
        .save_req      (save_req),
`ifdef BK_AUTOSAVE_EN
        .dirty_set     (dirty_set),
        .autosave_tick (autosave_tick),
`endif
        .sd            (sd_bus),
        .bk_ena        (bk_ena),
        .bk_loading    (bk_loading),
        .bk_busy       (bk_busy)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk_sys);
            #1;
        end
    endtask

    task automatic push_run(input int base, input int n, input logic rd, input logic loading);
        for (int i = 0; i < n; i++) begin
            q.push_back('{lba: 32'(base + i), rd: rd, wr: ~rd, loading: loading});
        end
    endtask

    task automatic wait_idle(input string name, input int budget);
        int c = 0;
        while (bk_busy && c < budget) begin
            step();
            c++;
        end
        check(name, 64'(bk_busy), 64'd0);
    endtask

`ifdef BK_AUTOSAVE_EN
    task automatic tick();
        autosave_tick = 1'b1;
        step();
        autosave_tick = 1'b0;
        step();
    endtask

    task automatic dirty();
        dirty_set = 1'b1;
        step();
        dirty_set = 1'b0;
    endtask
`endif

    // HPS model: raise ack one cycle after a request, drop it once the request is withdrawn.
    initial begin
        sd_bus.sd_ack = 1'b0;
        forever begin
            @(posedge clk_sys);
            #1;
            if ((sd_bus.sd_rd || sd_bus.sd_wr) && !sd_bus.sd_ack) begin
                sd_bus.sd_ack = 1'b1;
            end else if (sd_bus.sd_ack && !sd_bus.sd_rd && !sd_bus.sd_wr) begin
                sd_bus.sd_ack = 1'b0;
            end
        end
    end

    // Monitor: every new request pulse must match the head of the expectation queue.
    initial begin
        logic prev;
        logic cur;
        exp_t e;
        prev = 1'b0;
        forever begin
            @(negedge clk_sys);
            cur = sd_bus.sd_rd | sd_bus.sd_wr;
            if (cur && !prev) begin
                if (q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_pulse: got lba %0d rd %0b wr %0b, expected none",
                             sd_bus.sd_lba, sd_bus.sd_rd, sd_bus.sd_wr);
                end else begin
                    e = q.pop_front();
                    check("pulse_lba", 64'(sd_bus.sd_lba), 64'(e.lba));
                    check("pulse_rd", 64'(sd_bus.sd_rd), 64'(e.rd));
                    check("pulse_wr", 64'(sd_bus.sd_wr), 64'(e.wr));
                    check("pulse_loading", 64'(bk_loading), 64'(e.loading));
                end
            end
            prev = cur;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        int c;
        RESET_n       = 1'b0;
        downloading   = 1'b0;
        img_mounted   = 1'b0;
        img_readonly  = 1'b0;
        img_size      = 64'd0;
        slot          = 2'd0;
        load_req      = 1'b0;
        save_req      = 1'b0;
        dirty_set     = 1'b0;
        autosave_tick = 1'b0;
        step(2);
        check("rst_lba", 64'(sd_bus.sd_lba), 64'd0);
        check("rst_rd", 64'(sd_bus.sd_rd), 64'd0);
        check("rst_wr", 64'(sd_bus.sd_wr), 64'd0);
        check("rst_ena", 64'(bk_ena), 64'd0);
        check("rst_loading", 64'(bk_loading), 64'd0);
        check("rst_busy", 64'(bk_busy), 64'd0);
        RESET_n = 1'b1;
        step();

        // Enable handling
        downloading = 1'b1;
        step();
        check("ena_dl_rise", 64'(bk_ena), 64'd0);
        img_mounted  = 1'b1;
        img_size     = 64'd8192;
        img_readonly = 1'b1;
        step();
        img_mounted = 1'b0;
        check("ena_ro_mount", 64'(bk_ena), 64'd0);
        img_readonly = 1'b0;
        img_mounted  = 1'b1;
        step();
        img_mounted = 1'b0;
        check("ena_mount", 64'(bk_ena), 64'd1);
        downloading = 1'b0;
        step();
        check("ena_dl_fall_holds", 64'(bk_ena), 64'd1);
        downloading = 1'b1;
        step();
        check("ena_dl_rise2", 64'(bk_ena), 64'd0);
        img_mounted = 1'b1;
        step();
        img_mounted = 1'b0;
        downloading = 1'b0;
        step();
        check("ena_remount", 64'(bk_ena), 64'd1);

        // Save of slot 2; slot change mid-transfer must be ignored
        slot = 2'd2;
        push_run(128, 64, 1'b0, 1'b0);
        save_req = 1'b1;
        step();
        check("save_busy", 64'(bk_busy), 64'd1);
        slot = 2'd1;
        wait_idle("save_done", 600);
        check("save_q_empty", 64'(q.size()), 64'd0);
        step(5);
        check("save_level_no_retrig", 64'(bk_busy), 64'd0);
        save_req = 1'b0;
        step();

        // Simultaneous load and save edges on slot 1: load wins
        push_run(64, 64, 1'b1, 1'b1);
        load_req = 1'b1;
        save_req = 1'b1;
        step();
        check("both_busy", 64'(bk_busy), 64'd1);
        check("both_loading", 64'(bk_loading), 64'd1);
        step();
        check("both_rd", 64'(sd_bus.sd_rd), 64'd1);
        check("both_wr", 64'(sd_bus.sd_wr), 64'd0);
        wait_idle("load_done", 600);
        check("load_loading_clear", 64'(bk_loading), 64'd0);
        check("load_q_empty", 64'(q.size()), 64'd0);
        load_req = 1'b0;
        save_req = 1'b0;
        step();

        // Reset during sector 10 of a load of slot 0
        slot = 2'd0;
        push_run(0, 11, 1'b1, 1'b1);
        load_req = 1'b1;
        c = 0;
        while (!(sd_bus.sd_rd && sd_bus.sd_lba == 32'd10) && c < 200) begin
            step();
            c++;
        end
        check("reach_sector10", 64'(sd_bus.sd_lba), 64'd10);
        @(negedge clk_sys);
        #1;
        RESET_n = 1'b0;
        #1;
        check("mid_rst_lba", 64'(sd_bus.sd_lba), 64'd0);
        check("mid_rst_rd", 64'(sd_bus.sd_rd), 64'd0);
        check("mid_rst_wr", 64'(sd_bus.sd_wr), 64'd0);
        check("mid_rst_ena", 64'(bk_ena), 64'd0);
        check("mid_rst_loading", 64'(bk_loading), 64'd0);
        check("mid_rst_busy", 64'(bk_busy), 64'd0);
        step(2);
        RESET_n = 1'b1;
        step(10);
        check("post_rst_busy", 64'(bk_busy), 64'd0);
        check("post_rst_rd", 64'(sd_bus.sd_rd), 64'd0);
        check("post_rst_q_empty", 64'(q.size()), 64'd0);
        load_req = 1'b0;
        step();

`ifdef BK_AUTOSAVE_EN
        downloading = 1'b1;
        step();
        img_mounted = 1'b1;
        step();
        img_mounted = 1'b0;
        downloading = 1'b0;
        step();
        check("auto_ena", 64'(bk_ena), 64'd1);
        slot = 2'd3;
        push_run(192, 64, 1'b0, 1'b0);
        dirty();
        tick();
        tick();
        check("auto_wait_2", 64'(bk_busy), 64'd0);
        tick();
        check("auto_start", 64'(bk_busy), 64'd1);
        wait_idle("auto_done", 600);
        check("auto_q_empty", 64'(q.size()), 64'd0);

        push_run(192, 64, 1'b0, 1'b0);
        dirty();
        tick();
        tick();
        dirty();
        tick();
        tick();
        check("auto_delay_wait", 64'(bk_busy), 64'd0);
        tick();
        check("auto_delay_start", 64'(bk_busy), 64'd1);
        wait_idle("auto_delay_done", 600);
        check("auto_delay_q_empty", 64'(q.size()), 64'd0);
`endif

        step(3);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
